// File: rtl/ods_row_buffer.sv
// Row-steering capture column feeding an elastic chain of column stages.
// Words fill NUM_ROWS rows (auto or explicit select); full columns drain through DEPTH-1 stages.
module ods_row_buffer #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NUM_ROWS      = 3,
  parameter int DEPTH         = 2,
  parameter int ROW_W         = $clog2(NUM_ROWS)
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic                              mode_auto,
  input  logic [ROW_W-1:0]                  sel_row,
  input  logic [IO_DATA_WIDTH-1:0]          in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [NUM_ROWS*IO_DATA_WIDTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              sel_err,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  typedef logic [NUM_ROWS-1:0][IO_DATA_WIDTH-1:0] col_t;

  col_t                r_cap;
  logic [NUM_ROWS-1:0] r_wr;
  col_t                r_stg [1:DEPTH-1];
  logic [DEPTH-1:1]    r_vld;
  logic                r_sel_err;
  logic [OCC_W-1:0]    r_occ;

  logic                w_cap_full;
  logic                w_bad_sel;
  logic                w_accept;
  logic                w_sink;
  logic                w_flush;
  logic [DEPTH-1:0]    w_go;
  logic [NUM_ROWS-1:0] w_base;
  logic [NUM_ROWS-1:0] w_oh_auto;
  logic [NUM_ROWS-1:0] w_oh_sel;
  logic [NUM_ROWS-1:0] w_wen;
  logic [NUM_ROWS-1:0] w_wr_mid;
  logic [NUM_ROWS-1:0] w_wr_nxt;
  logic [DEPTH-1:1]    w_vld_nxt;
  logic [OCC_W-1:0]    w_occ_nxt;

  assign w_cap_full = &r_wr;
  assign w_bad_sel  = !mode_auto && (32'(sel_row) >= 32'(NUM_ROWS));

  // A stage moves when any hole exists downstream of it or the output drains;
  // w_go[0] is the capture column advancing into stage 1.
  always_comb begin
    w_go   = '0;
    w_sink = out_ready;
    for (int k = DEPTH-1; k >= 1; k--) begin
      w_go[k] = r_vld[k] && w_sink;
      w_sink  = w_sink || !r_vld[k];
    end
    w_go[0] = w_cap_full && w_sink;
  end

  assign in_ready = !rst_in && !w_bad_sel && (!w_cap_full || w_go[0]);
  assign w_accept = in_valid && in_ready;

  // Written bits as seen by this cycle's write: a departing column frees all rows.
  assign w_base    = w_go[0] ? '0 : r_wr;
  assign w_oh_auto = ~w_base & (w_base + NUM_ROWS'(1));

  always_comb begin
    w_oh_sel = '0;
    for (int r = 0; r < NUM_ROWS; r++) w_oh_sel[r] = (sel_row == ROW_W'(r));
  end

  assign w_wen    = w_accept ? (mode_auto ? w_oh_auto : w_oh_sel) : '0;
  assign w_wr_mid = w_base | w_wen;
  assign w_flush  = flush && !w_cap_full && (|w_wr_mid);
  assign w_wr_nxt = w_flush ? '1 : w_wr_mid;

  always_comb begin
    w_vld_nxt = '0;
    w_occ_nxt = OCC_W'(&w_wr_nxt);
    for (int k = 1; k < DEPTH; k++) begin
      w_vld_nxt[k] = (r_vld[k] && !w_go[k]) || w_go[k-1];
      w_occ_nxt    = w_occ_nxt + OCC_W'(w_vld_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_cap     <= '0;
      r_wr      <= '0;
      r_vld     <= '0;
      r_sel_err <= 1'b0;
      r_occ     <= '0;
      for (int k = 1; k < DEPTH; k++) r_stg[k] <= '0;
    end else begin
      r_wr      <= w_wr_nxt;
      r_vld     <= w_vld_nxt;
      r_sel_err <= in_valid && w_bad_sel;
      r_occ     <= w_occ_nxt;
      // Flush pads never-written rows with zero; written rows keep their word.
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (w_wen[r])                      r_cap[r] <= in_data;
        else if (w_flush && !w_wr_mid[r])  r_cap[r] <= '0;
      end
      if (w_go[0]) r_stg[1] <= r_cap;
      for (int k = 2; k < DEPTH; k++) begin
        if (w_go[k-1]) r_stg[k] <= r_stg[k-1];
      end
    end
  end

  assign out_data  = r_stg[DEPTH-1];
  assign out_valid = r_vld[DEPTH-1];
  assign sel_err   = r_sel_err;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_ods_row_buffer.sv
// Bench for ods_row_buffer (3 rows, 3 stages): vector table, corner sequences,
// and random traffic against a column-queue reference model.
module tb_ods_row_buffer;

  localparam int W  = 16;
  localparam int NR = 3;
  localparam int D  = 3;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          mode_auto = 1'b1;
  logic [1:0]    sel_row = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [NR*W-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          sel_err;
  logic [1:0]    occupancy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ods_row_buffer #(.IO_DATA_WIDTH(W), .NUM_ROWS(NR), .DEPTH(D)) dut (
    .clk(clk), .rst_in(rst_in), .mode_auto(mode_auto), .sel_row(sel_row),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .occupancy(occupancy)
  );

  // Reference model: capture rows plus an ordered queue of columns with positions.
  typedef struct { logic [NR*W-1:0] d; int pos; } mcol_t;
  mcol_t                 m_q[$];
  logic [NR-1:0][W-1:0]  m_cap = '0;
  logic [NR-1:0]         m_wr = '0;
  logic [NR*W-1:0]       m_last = '0;
  bit                    m_err = 0;
  bit                    m_rdy = 0;
  logic [NR*W-1:0]       beats[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_step(input bit v, input bit ma, input logic [1:0] sel,
                        input logic [W-1:0] d, input bit fl, input bit ordy, input bit rst);
    mcol_t nq[$];
    mcol_t c;
    int lim, idx;
    bit bad, full, free1, adv, acc;
    if (rst) begin
      m_rdy = 0; m_q.delete(); m_wr = '0; m_cap = '0; m_last = '0; m_err = 0;
      return;
    end
    bad  = !ma && (int'(sel) >= NR);
    full = &m_wr;
    lim  = D;
    for (int i = 0; i < m_q.size(); i++) begin
      c = m_q[i];
      if (i == 0 && c.pos == D-1 && ordy) continue;
      if (c.pos + 1 < lim) begin
        c.pos++;
        if (c.pos == D-1) m_last = c.d;
      end
      lim = c.pos;
      nq.push_back(c);
    end
    free1 = (nq.size() == 0) || (nq[nq.size()-1].pos != 1);
    adv   = full && free1;
    m_rdy = !bad && (!full || adv);
    acc   = v && m_rdy;
    if (adv) begin
      c.d = m_cap; c.pos = 1;
      nq.push_back(c);
      m_wr = '0;
    end
    if (acc) begin
      idx = int'(sel);
      if (ma) begin
        idx = -1;
        for (int i = NR-1; i >= 0; i--) if (!m_wr[i]) idx = i;
      end
      m_cap[idx] = d;
      m_wr[idx]  = 1'b1;
    end
    if (fl && !full && (|m_wr)) begin
      for (int i = 0; i < NR; i++) if (!m_wr[i]) m_cap[i] = '0;
      m_wr = '1;
    end
    m_err = v && bad;
    m_q = nq;
  endtask

  // One clock: drive, check in_ready, step the model, check registered outputs.
  task automatic tick(input bit v, input bit ma, input logic [1:0] sel, input logic [W-1:0] d,
                      input bit fl, input bit ordy, input bit rst, output bit rdy);
    in_valid = v; mode_auto = ma; sel_row = sel; in_data = d;
    flush = fl; out_ready = ordy; rst_in = rst;
    #1;
    rdy = in_ready;
    m_step(v, ma, sel, d, fl, ordy, rst);
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    if (out_valid && out_ready) beats.push_back(out_data);
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, (m_q.size() > 0 && m_q[0].pos == D-1)});
    chk("out_data", 64'(out_data), 64'(m_last));
    chk("sel_err", {63'd0, sel_err}, {63'd0, m_err});
    chk("occupancy", 64'(occupancy), 64'(m_q.size() + int'(&m_wr)));
  endtask

  typedef struct {
    bit v; bit ma; logic [1:0] sel; logic [W-1:0] d; bit fl; bit ordy;
    bit e_rdy; bit e_ov; logic [NR*W-1:0] e_od; bit e_err; logic [1:0] e_occ;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input bit ma, input logic [1:0] sel, input logic [W-1:0] d,
                     input bit erdy, input bit eov, input logic [NR*W-1:0] eod,
                     input bit eerr, input logic [1:0] eocc);
    vec_t e;
    e.v = v; e.ma = ma; e.sel = sel; e.d = d; e.fl = 0; e.ordy = 1;
    e.e_rdy = erdy; e.e_ov = eov; e.e_od = eod; e.e_err = eerr; e.e_occ = eocc;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    bit r;
    tick(1, 1, 0, 16'h1234, 0, 1, 1, r);
    chk("reset_in_ready", {63'd0, r}, 64'd0);
    tick(0, 1, 0, 16'h0, 0, 1, 1, r);
  endtask

  initial begin
    bit r;
    // AUTO back-to-back columns, then SEL with overwrite, bad select, recovery.
    add(1,1,0,16'h0011, 1,0,'0,0,0);
    add(1,1,0,16'h0022, 1,0,'0,0,0);
    add(1,1,0,16'h0033, 1,0,'0,0,1);
    add(1,1,0,16'h0044, 1,0,'0,0,1);
    add(1,1,0,16'h0055, 1,1,{16'h0033,16'h0022,16'h0011},0,1);
    add(1,1,0,16'h0066, 1,0,'0,0,1);
    add(0,1,0,16'h0000, 1,0,'0,0,1);
    add(0,1,0,16'h0000, 1,1,{16'h0066,16'h0055,16'h0044},0,1);
    add(0,1,0,16'h0000, 1,0,'0,0,0);
    add(1,0,2,16'h000C, 1,0,'0,0,0);
    add(1,0,0,16'h000A, 1,0,'0,0,0);
    add(1,0,0,16'h00AA, 1,0,'0,0,0);
    add(1,0,1,16'h000B, 1,0,'0,0,1);
    add(0,0,0,16'h0000, 1,0,'0,0,1);
    add(0,0,0,16'h0000, 1,1,{16'h000C,16'h000B,16'h00AA},0,1);
    add(1,0,3,16'hDEAD, 0,0,'0,1,0);
    add(0,1,0,16'h0000, 1,0,'0,0,0);
    add(1,1,3,16'h0101, 1,0,'0,0,0);
    add(1,1,3,16'h0202, 1,0,'0,0,0);
    add(1,1,3,16'h0303, 1,0,'0,0,1);
    add(0,1,0,16'h0000, 1,0,'0,0,1);
    add(0,1,0,16'h0000, 1,1,{16'h0303,16'h0202,16'h0101},0,1);
    add(0,1,0,16'h0000, 1,0,'0,0,0);

    do_reset();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_sel_err", {63'd0, sel_err}, 64'd0);
    chk("reset_occupancy", 64'(occupancy), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].v, tbl[i].ma, tbl[i].sel, tbl[i].d, tbl[i].fl, tbl[i].ordy, 0, r);
      chk($sformatf("tbl%0d_rdy", i), {63'd0, r}, {63'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_ov", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_od", i), 64'(out_data), 64'(tbl[i].e_od));
      chk($sformatf("tbl%0d_err", i), {63'd0, sel_err}, {63'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
    end

    // Full stall: two columns in the chain plus a full capture column.
    do_reset();
    beats.delete();
    for (int i = 1; i <= 9; i++) begin
      tick(1, 1, 0, W'(i), 0, 0, 0, r);
      chk("bp_accept", {63'd0, r}, 64'd1);
      if (i == 7 || i == 8) chk("bp_occ_partial", 64'(occupancy), 64'd2);
    end
    chk("bp_occ_full", 64'(occupancy), 64'd3);
    tick(1, 1, 0, 16'h000A, 0, 0, 0, r);
    chk("bp_stall_ready", {63'd0, r}, 64'd0);
    chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_hold_data", 64'(out_data), 64'({16'd3, 16'd2, 16'd1}));
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 16'h0, 0, 1, 0, r);
    chk("bp_beat_count", 64'(beats.size()), 64'd3);
    if (beats.size() == 3) begin
      chk("bp_beat0", 64'(beats[0]), 64'({16'd3, 16'd2, 16'd1}));
      chk("bp_beat1", 64'(beats[1]), 64'({16'd6, 16'd5, 16'd4}));
      chk("bp_beat2", 64'(beats[2]), 64'({16'd9, 16'd8, 16'd7}));
    end

    // Flush together with the first word, then flush on an empty column.
    do_reset();
    tick(1, 1, 0, 16'hABCD, 1, 1, 0, r);
    chk("fl_occ", 64'(occupancy), 64'd1);
    tick(0, 1, 0, 16'h0, 0, 1, 0, r);
    tick(0, 1, 0, 16'h0, 0, 1, 0, r);
    chk("fl_beat_valid", {63'd0, out_valid}, 64'd1);
    chk("fl_beat_data", 64'(out_data), 64'({16'h0, 16'h0, 16'hABCD}));
    tick(0, 1, 0, 16'h0, 1, 1, 0, r);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 16'h0, 0, 1, 0, r);
      chk("fl_empty_no_beat", {63'd0, out_valid}, 64'd0);
      chk("fl_empty_occ", 64'(occupancy), 64'd0);
    end

    // Reset with one queued column and two rows written.
    for (int i = 1; i <= 5; i++) tick(1, 1, 0, W'(16'h0E00 + i), 0, 0, 0, r);
    chk("rst_pre_occ", 64'(occupancy), 64'd1);
    tick(1, 1, 0, 16'h0E06, 0, 0, 1, r);
    chk("rst_mid_ready", {63'd0, r}, 64'd0);
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_occ", 64'(occupancy), 64'd0);
    for (int i = 1; i <= 3; i++) tick(1, 1, 0, W'(16'h0A00 + i), 0, 1, 0, r);
    tick(0, 1, 0, 16'h0, 0, 1, 0, r);
    tick(0, 1, 0, 16'h0, 0, 1, 0, r);
    chk("rst_fresh_valid", {63'd0, out_valid}, 64'd1);
    chk("rst_fresh_data", 64'(out_data), 64'({16'h0A03, 16'h0A02, 16'h0A01}));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           W'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) == 0), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
